// File: rtl/shapool_pkg.sv
// rtl/shapool_pkg.sv - shared result record width, record builder and LED mode encoding
package shapool_pkg;

  localparam int RESULT_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    LED_OFF  = 2'd0,
    LED_SLOW = 2'd1,
    LED_FAST = 2'd2,
    LED_ON   = 2'd3
  } led_mode_e;

  // Record layout is {zero pad, pool_id, nonce}; pool_id sits directly above the nonce.
  function automatic logic [RESULT_DATA_WIDTH-1:0] make_record(
    input logic [31:0] pool_id,
    input logic [31:0] nonce,
    input int          nonce_width
  );
    return (pool_id << nonce_width) | nonce;
  endfunction

endpackage

// File: rtl/result_collector_if.sv
// rtl/result_collector_if.sv - pool/host side signal bundle of the result collector
interface result_collector_if #(
  parameter int NUM_POOLS       = 4,
  parameter int NONCE_WIDTH     = 30,
  parameter int FIFO_DEPTH_LOG2 = 2
);
  import shapool_pkg::*;

  logic                             job_start_in;
  logic [NUM_POOLS-1:0]             success_in;
  logic [NUM_POOLS*NONCE_WIDTH-1:0] nonce_in;
  logic                             pop_in;
  logic [RESULT_DATA_WIDTH-1:0]     result_out;
  logic                             result_valid_out;
  logic [FIFO_DEPTH_LOG2:0]         count_out;
  logic                             overflow_out;
  logic                             halt_out;
  logic                             ready_oe_out;
  logic                             status_led_n_out;

  modport master (
    output job_start_in, success_in, nonce_in, pop_in,
    input  result_out, result_valid_out, count_out, overflow_out,
    input  halt_out, ready_oe_out, status_led_n_out
  );

  modport slave (
    input  job_start_in, success_in, nonce_in, pop_in,
    output result_out, result_valid_out, count_out, overflow_out,
    output halt_out, ready_oe_out, status_led_n_out
  );

endinterface

// File: rtl/result_fifo.sv
// rtl/result_fifo.sv - read-first synchronous FIFO with registered count and flush
module result_fifo #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 4,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  clk_in,
  input  logic                  reset_in,
  input  logic                  flush,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      din,
  output logic [WIDTH-1:0]      dout,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty
);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (DEPTH_LOG2+1)'(DEPTH));
  assign dout    = mem[rd_ptr];
  assign do_pop  = pop & ~empty;
  // A pop frees the slot in the same cycle, so a full FIFO still accepts a push.
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk_in) begin
    if (reset_in || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/result_collector.sv
// rtl/result_collector.sv - captures per-pool success nonces, round-robin queues them for readout
module result_collector
  import shapool_pkg::*;
#(
  parameter int NUM_POOLS       = 4,
  parameter int NUM_POOLS_LOG2  = 2,
  parameter int NONCE_WIDTH     = 30,
  parameter int FIFO_DEPTH      = 4,
  parameter int FIFO_DEPTH_LOG2 = 2,
  parameter int LED_DIV_LOG2    = 22
) (
  input  logic               clk_in,
  input  logic               reset_in,
  result_collector_if.slave  bus
);

  logic [NUM_POOLS-1:0]         success_q;
  logic [NUM_POOLS-1:0]         pending;
  logic [NUM_POOLS-1:0]         rise;
  logic [NUM_POOLS-1:0]         grant_vec;
  logic [NONCE_WIDTH-1:0]       hold [NUM_POOLS];
  logic [NUM_POOLS_LOG2-1:0]    rr_ptr;
  logic [NUM_POOLS_LOG2-1:0]    grant_id;
  logic [NUM_POOLS_LOG2-1:0]    cand;
  logic                         grant_valid;
  logic                         fifo_full;
  logic                         fifo_empty;
  logic                         fifo_pop;
  logic                         space;
  logic                         overflow;
  logic                         job_active;
  logic [LED_DIV_LOG2-1:0]      led_cnt;
  logic [RESULT_DATA_WIDTH-1:0] fifo_din;
  logic [RESULT_DATA_WIDTH-1:0] fifo_dout;
  logic [FIFO_DEPTH_LOG2:0]     fifo_count;
  led_mode_e                    led_mode;
  logic                         led_n;

  assign rise     = bus.success_in & ~success_q;
  assign fifo_pop = bus.pop_in & ~fifo_empty & ~bus.job_start_in;
  assign space    = ~fifo_full | fifo_pop;

  // Round-robin search starting just after the last granted pool.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = '0;
    cand        = '0;
    for (int i = 1; i <= NUM_POOLS; i++) begin
      cand = NUM_POOLS_LOG2'((int'(rr_ptr) + i) % NUM_POOLS);
      if (!grant_valid && pending[cand]) begin
        grant_valid = 1'b1;
        grant_id    = cand;
      end
    end
    if (!space || bus.job_start_in) begin
      grant_valid = 1'b0;
    end
  end

  always_comb begin
    grant_vec = '0;
    for (int k = 0; k < NUM_POOLS; k++) begin
      grant_vec[k] = grant_valid && (grant_id == NUM_POOLS_LOG2'(k));
    end
  end

  assign fifo_din = make_record(32'(grant_id), 32'(hold[grant_id]), NONCE_WIDTH);

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      success_q  <= '0;
      pending    <= '0;
      rr_ptr     <= '0;
      overflow   <= 1'b0;
      job_active <= 1'b0;
      led_cnt    <= '0;
      for (int k = 0; k < NUM_POOLS; k++) begin
        hold[k] <= '0;
      end
    end else begin
      success_q <= bus.success_in;
      led_cnt   <= led_cnt + 1'b1;
      if (bus.job_start_in) begin
        pending    <= '0;
        rr_ptr     <= '0;
        overflow   <= 1'b0;
        job_active <= 1'b1;
      end else begin
        if (grant_valid) begin
          rr_ptr <= grant_id;
        end
        // A pool being granted this cycle frees its holding register for a new rise.
        for (int k = 0; k < NUM_POOLS; k++) begin
          if (rise[k]) begin
            if (pending[k] && !grant_vec[k]) begin
              overflow <= 1'b1;
            end else begin
              hold[k] <= bus.nonce_in[k*NONCE_WIDTH +: NONCE_WIDTH];
            end
          end
        end
        pending <= (pending & ~grant_vec) | rise;
      end
    end
  end

  result_fifo #(
    .WIDTH      (RESULT_DATA_WIDTH),
    .DEPTH      (FIFO_DEPTH),
    .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .flush    (bus.job_start_in),
    .push     (grant_valid),
    .pop      (fifo_pop),
    .din      (fifo_din),
    .dout     (fifo_dout),
    .count    (fifo_count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_comb begin
    led_mode = LED_OFF;
    if (!job_active) begin
      led_mode = LED_OFF;
    end else if (overflow) begin
      led_mode = LED_FAST;
    end else if (!fifo_empty) begin
      led_mode = LED_ON;
    end else begin
      led_mode = LED_SLOW;
    end
  end

  always_comb begin
    led_n = 1'b1;
    case (led_mode)
      LED_FAST: led_n = led_cnt[LED_DIV_LOG2-3];
      LED_SLOW: led_n = led_cnt[LED_DIV_LOG2-1];
      LED_ON:   led_n = 1'b0;
      default:  led_n = 1'b1;
    endcase
  end

  assign bus.result_out       = fifo_empty ? '0 : fifo_dout;
  assign bus.result_valid_out = ~fifo_empty;
  assign bus.count_out        = fifo_count;
  assign bus.overflow_out     = overflow;
  assign bus.halt_out         = fifo_full;
  assign bus.ready_oe_out     = ~fifo_empty;
  assign bus.status_led_n_out = led_n;

endmodule

// File: tb/tb_result_collector.sv
// tb/tb_result_collector.sv - randomized and directed checks of result_collector against a queue model
module tb_result_collector;

  localparam int NP = 4;
  localparam int NW = 30;
  localparam int FD = 4;
  localparam int LD = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  result_collector_if #(.NUM_POOLS(NP), .NONCE_WIDTH(NW), .FIFO_DEPTH_LOG2(2)) bus ();

  result_collector #(
    .NUM_POOLS(NP), .NUM_POOLS_LOG2(2), .NONCE_WIDTH(NW),
    .FIFO_DEPTH(FD), .FIFO_DEPTH_LOG2(2), .LED_DIV_LOG2(LD)
  ) dut (
    .clk_in   (clk),
    .reset_in (rst),
    .bus      (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rec(input int id, input logic [NW-1:0] nonce);
    return (32'(id) << NW) | 32'(nonce);
  endfunction

  // Reference model: a queue of records plus per-pool pending flag and held nonce.
  bit          m_started = 1'b0;
  logic [31:0] m_q[$];
  bit          m_pend[NP];
  logic [NW-1:0] m_hold[NP];
  bit          m_ovf;
  bit          m_active;
  int          m_rr;
  logic [NP-1:0] m_prev;
  logic [31:0] m_cnt;

  always @(posedge clk) begin : model
    logic [NP-1:0] s;
    logic [NP-1:0] r;
    bit popping;
    bit room;
    int id;
    if (rst) begin
      m_started = 1'b1;
      m_q.delete();
      for (int k = 0; k < NP; k++) begin
        m_pend[k] = 1'b0;
        m_hold[k] = '0;
      end
      m_ovf = 1'b0; m_active = 1'b0; m_rr = 0; m_prev = '0; m_cnt = '0;
    end else if (m_started) begin
      s = bus.success_in;
      r = s & ~m_prev;
      m_cnt = m_cnt + 1;
      if (bus.job_start_in) begin
        m_q.delete();
        for (int k = 0; k < NP; k++) m_pend[k] = 1'b0;
        m_ovf = 1'b0; m_rr = 0; m_active = 1'b1;
      end else begin
        popping = bus.pop_in && (m_q.size() > 0);
        room = (m_q.size() < FD) || popping;
        if (popping) void'(m_q.pop_front());
        if (room) begin
          for (int i = 1; i <= NP; i++) begin
            id = (m_rr + i) % NP;
            if (m_pend[id]) begin
              m_q.push_back(rec(id, m_hold[id]));
              m_pend[id] = 1'b0;
              m_rr = id;
              break;
            end
          end
        end
        for (int k = 0; k < NP; k++) begin
          if (r[k]) begin
            if (m_pend[k]) m_ovf = 1'b1;
            else begin
              m_pend[k] = 1'b1;
              m_hold[k] = bus.nonce_in[k*NW +: NW];
            end
          end
        end
      end
      m_prev = s;
    end
  end

  always @(negedge clk) begin : compare
    bit ev;
    bit el;
    if (m_started) begin
      ev = (m_q.size() > 0);
      if (!m_active) el = 1'b1;
      else if (m_ovf) el = m_cnt[LD-3];
      else if (ev) el = 1'b0;
      else el = m_cnt[LD-1];
      chk("m_result", bus.result_out, ev ? m_q[0] : 32'd0);
      chk("m_valid", 32'(bus.result_valid_out), 32'(ev));
      chk("m_count", 32'(bus.count_out), 32'(m_q.size()));
      chk("m_halt", 32'(bus.halt_out), 32'(m_q.size() == FD));
      chk("m_ready_oe", 32'(bus.ready_oe_out), 32'(ev));
      chk("m_overflow", 32'(bus.overflow_out), 32'(m_ovf));
      chk("m_led", 32'(bus.status_led_n_out), 32'(el));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_nonce(input int k, input logic [NW-1:0] v);
    bus.nonce_in[k*NW +: NW] = v;
  endtask

  logic [31:0] exp_heads [5];
  bit seen0, seen1;

  initial begin
    bus.job_start_in = 1'b0;
    bus.success_in   = '0;
    bus.nonce_in     = '0;
    bus.pop_in       = 1'b0;
    rst = 1'b1;
    step(); step();
    chk("rst_count", 32'(bus.count_out), 32'd0);
    chk("rst_valid", 32'(bus.result_valid_out), 32'd0);
    chk("rst_led", 32'(bus.status_led_n_out), 32'd1);
    chk("rst_halt", 32'(bus.halt_out), 32'd0);
    rst = 1'b0;

    // 1: single hit on pool 2
    bus.job_start_in = 1'b1; step(); bus.job_start_in = 1'b0;
    bus.success_in[2] = 1'b1; set_nonce(2, 30'h0ABCDEF);
    step();
    chk("t1_valid_early", 32'(bus.result_valid_out), 32'd0);
    step();
    chk("t1_valid", 32'(bus.result_valid_out), 32'd1);
    chk("t1_result", bus.result_out, 32'h80ABCDEF);
    chk("t1_led_on", 32'(bus.status_led_n_out), 32'd0);
    bus.pop_in = 1'b1; step(); bus.pop_in = 1'b0;
    chk("t1_pop_valid", 32'(bus.result_valid_out), 32'd0);
    chk("t1_pop_count", 32'(bus.count_out), 32'd0);
    bus.success_in = '0;

    // 2: all pools rise together with rr_ptr cleared
    bus.job_start_in = 1'b1; step(); bus.job_start_in = 1'b0;
    for (int k = 0; k < NP; k++) set_nonce(k, NW'(32'h100 + k));
    bus.success_in = 4'hF;
    step();
    chk("t2_count0", 32'(bus.count_out), 32'd0);
    step();
    chk("t2_first", bus.result_out, 32'h40000101);
    step(); step(); step();
    chk("t2_count", 32'(bus.count_out), 32'd4);
    chk("t2_halt", 32'(bus.halt_out), 32'd1);

    // 3: pool 1 rises while full, then push and pop together
    bus.success_in[1] = 1'b0; step();
    bus.success_in[1] = 1'b1; set_nonce(1, 30'h2222); step();
    step();
    chk("t3_held", 32'(bus.count_out), 32'd4);
    bus.pop_in = 1'b1; step(); bus.pop_in = 1'b0;
    chk("t3_count", 32'(bus.count_out), 32'd4);
    chk("t3_head", bus.result_out, 32'h80000102);

    // 4: pool 0 rises twice while pending, full, no pop
    bus.success_in[0] = 1'b0; step();
    bus.success_in[0] = 1'b1; set_nonce(0, 30'h3333); step();
    bus.success_in[0] = 1'b0; step();
    bus.success_in[0] = 1'b1; set_nonce(0, 30'h4444); step();
    chk("t4_overflow", 32'(bus.overflow_out), 32'd1);
    seen0 = 1'b0; seen1 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (bus.status_led_n_out === 1'b0) seen0 = 1'b1;
      if (bus.status_led_n_out === 1'b1) seen1 = 1'b1;
    end
    chk("t4_led_blinks", 32'({seen0, seen1}), 32'd3);
    exp_heads[0] = 32'h80000102;
    exp_heads[1] = 32'hC0000103;
    exp_heads[2] = 32'h00000100;
    exp_heads[3] = 32'h40002222;
    exp_heads[4] = 32'h00003333;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t4_head%0d", i), bus.result_out, exp_heads[i]);
      bus.pop_in = 1'b1; step(); bus.pop_in = 1'b0;
    end
    chk("t4_drained", 32'(bus.count_out), 32'd0);

    // 5: pool 3 rising with job_start and held afterwards
    bus.success_in = '0; step();
    bus.job_start_in = 1'b1; bus.success_in[3] = 1'b1; step(); bus.job_start_in = 1'b0;
    step(); step(); step();
    chk("t5_count", 32'(bus.count_out), 32'd0);
    chk("t5_overflow", 32'(bus.overflow_out), 32'd0);

    // 6: reset with three records queued
    bus.success_in = 4'hF; step();
    step(); step(); step();
    chk("t6_count3", 32'(bus.count_out), 32'd3);
    rst = 1'b1; bus.success_in = '0; step(); rst = 1'b0;
    chk("t6_count", 32'(bus.count_out), 32'd0);
    chk("t6_ready_oe", 32'(bus.ready_oe_out), 32'd0);
    chk("t6_led", 32'(bus.status_led_n_out), 32'd1);
    bus.pop_in = 1'b1; step(); bus.pop_in = 1'b0;
    chk("t6_pop_ignored", 32'(bus.count_out), 32'd0);

    // Random traffic against the model
    bus.job_start_in = 1'b1; step(); bus.job_start_in = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      for (int k = 0; k < NP; k++) begin
        if ($urandom_range(0, 3) == 0) bus.success_in[k] = ~bus.success_in[k];
        set_nonce(k, NW'($urandom));
      end
      bus.pop_in       = ($urandom_range(0, 2) == 0);
      bus.job_start_in = ($urandom_range(0, 99) == 0);
      rst              = ($urandom_range(0, 399) == 0);
      step();
    end
    rst = 1'b0; bus.job_start_in = 1'b0; bus.pop_in = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
